rps_round_ctrl: RTL

//   Round sequencer for the rock-paper-scissors game. Consumes the level output
//   of the cycle timer (hit_target) and drives the timer's enable (in). It runs
//   a countdown of beats, samples both players' moves on the last beat, judges
//   the round, keeps saturating scores and holds the result for one display

---
 rtl/rps_round_ctrl_if.sv | 23 ++
 rtl/rps_round_ctrl.sv | 129 ++++++++++++
 2 files changed

// File: rtl/rps_round_ctrl_if.sv
// rps_round_ctrl_if: player/timer inputs and display/timer outputs of the round sequencer
interface rps_round_ctrl_if #(parameter int SCORE_W = 4);
   logic               start;
   logic               timer_hit;
   logic [1:0]         p1_move;
   logic [1:0]         p2_move;
   logic               timer_en;
   logic               beat;
   logic [1:0]         beats_left;
   logic [1:0]         result;
   logic [SCORE_W-1:0] p1_score;
   logic [SCORE_W-1:0] p2_score;
   logic               busy;
   logic               game_over;
   modport master (
      output start, timer_hit, p1_move, p2_move,
      input  timer_en, beat, beats_left, result, p1_score, p2_score, busy, game_over
   );
   modport slave (
      input  start, timer_hit, p1_move, p2_move,
      output timer_en, beat, beats_left, result, p1_score, p2_score, busy, game_over
   );
endinterface

// File: rtl/rps_round_ctrl.sv
// rps_round_ctrl: beat countdown, move sampling, judging and saturating scores for rock-paper-scissors
module rps_round_ctrl #(
   parameter int COUNT_BEATS = 3,
   parameter int SCORE_W     = 4,
   parameter int WIN_SCORE   = 5
) (
   input  logic            clk,
   input  logic            reset,
   rps_round_ctrl_if.slave bus
);
   typedef enum logic [2:0] {IDLE, COUNT, SAMPLE, JUDGE, SHOW, OVER} state_t;
   localparam logic [1:0]         BEATS = 2'(COUNT_BEATS);
   localparam logic [SCORE_W-1:0] WIN   = SCORE_W'(WIN_SCORE);
   state_t             state_q, state_d;
   logic               timer_en_q, timer_en_d;
   logic               beat_q, beat_d;
   logic [1:0]         beats_q, beats_d;
   logic [1:0]         result_q, result_d;
   logic [SCORE_W-1:0] p1s_q, p1s_d, p2s_q, p2s_d;
   logic [1:0]         m1_q, m1_d, m2_q, m2_d;
   logic               busy_q, busy_d, over_q, over_d;
   logic               p1_wins;
   logic [1:0]         verdict;
   // a missing move loses to any real move; otherwise rock>scissors>paper>rock
   assign p1_wins = (m2_q == 2'b00) || ({m1_q, m2_q} == 4'b0111) ||
                    ({m1_q, m2_q} == 4'b1110) || ({m1_q, m2_q} == 4'b1001);
   assign verdict = (m1_q == m2_q) ? 2'b11 : (p1_wins ? 2'b01 : 2'b10);
   assign bus.timer_en   = timer_en_q;
   assign bus.beat       = beat_q;
   assign bus.beats_left = beats_q;
   assign bus.result     = result_q;
   assign bus.p1_score   = p1s_q;
   assign bus.p2_score   = p2s_q;
   assign bus.busy       = busy_q;
   assign bus.game_over  = over_q;
   // next-state and next-output logic; every output is registered
   always_comb begin
      state_d    = state_q;
      timer_en_d = timer_en_q;
      beat_d     = 1'b0;
      beats_d    = beats_q;
      result_d   = result_q;
      p1s_d      = p1s_q;
      p2s_d      = p2s_q;
      m1_d       = m1_q;
      m2_d       = m2_q;
      case (state_q)
         IDLE: begin
            timer_en_d = 1'b0;
            if (bus.start) begin
               state_d    = COUNT;
               beats_d    = BEATS;
               timer_en_d = 1'b1;
               result_d   = 2'b00;
            end
         end
         COUNT: begin
            if (!timer_en_q) timer_en_d = 1'b1;
            else if (bus.timer_hit) begin
               timer_en_d = 1'b0;
               beat_d     = 1'b1;
               if (beats_q == 2'd1) state_d = SAMPLE;
               else beats_d = beats_q - 2'd1;
            end
         end
         SAMPLE: begin
            m1_d       = bus.p1_move;
            m2_d       = bus.p2_move;
            timer_en_d = 1'b0;
            state_d    = JUDGE;
         end
         JUDGE: begin
            result_d   = verdict;
            p1s_d      = (verdict == 2'b01 && p1s_q != WIN) ? p1s_q + 1'b1 : p1s_q;
            p2s_d      = (verdict == 2'b10 && p2s_q != WIN) ? p2s_q + 1'b1 : p2s_q;
            timer_en_d = 1'b1;
            state_d    = SHOW;
         end
         SHOW: begin
            if (timer_en_q && bus.timer_hit) begin
               timer_en_d = 1'b0;
               state_d    = (p1s_q == WIN || p2s_q == WIN) ? OVER : IDLE;
            end
         end
         OVER: begin
            timer_en_d = 1'b0;
            if (bus.start) begin
               state_d    = COUNT;
               beats_d    = BEATS;
               timer_en_d = 1'b1;
               result_d   = 2'b00;
               p1s_d      = '0;
               p2s_d      = '0;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == COUNT) || (state_d == SAMPLE) || (state_d == JUDGE) || (state_d == SHOW);
      over_d = (state_d == OVER);
   end
   // state and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         timer_en_q <= 1'b0;
         beat_q     <= 1'b0;
         beats_q    <= 2'b00;
         result_q   <= 2'b00;
         p1s_q      <= '0;
         p2s_q      <= '0;
         m1_q       <= 2'b00;
         m2_q       <= 2'b00;
         busy_q     <= 1'b0;
         over_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_en_q <= timer_en_d;
         beat_q     <= beat_d;
         beats_q    <= beats_d;
         result_q   <= result_d;
         p1s_q      <= p1s_d;
         p2s_q      <= p2s_d;
         m1_q       <= m1_d;
         m2_q       <= m2_d;
         busy_q     <= busy_d;
         over_q     <= over_d;
      end
   end
endmodule
